// File: rtl/sram_bank_arbiter_if.sv
// Requester-side and bank-side signals of the shared SRAM bank arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the bank macro.
interface sram_bank_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]                 req_i;
  logic [NUM_PORTS-1:0]                 we_i;
  logic [NUM_PORTS-1:0]                 lock_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS-1:0][BeWidth-1:0]    be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_PORTS-1:0]                 gnt_o;
  logic [NUM_PORTS-1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]                rdata_o;

  logic                                 sram_cs_o;
  logic                                 sram_we_o;
  logic [ADDR_WIDTH-1:0]                sram_addr_o;
  logic [BeWidth-1:0]                   sram_be_o;
  logic [DATA_WIDTH-1:0]                sram_wdata_o;
  logic [DATA_WIDTH-1:0]                sram_rdata_i;

  modport slave (
    input  req_i, we_i, lock_i, addr_i, be_i, wdata_i, sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output sram_cs_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o
  );

  modport master (
    output req_i, we_i, lock_i, addr_i, be_i, wdata_i, sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  sram_cs_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one single-port SRAM bank;
// read data is routed back to the issuing port through a fixed-latency tag pipe.
module sram_bank_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned MAX_LOCK_BEATS = 16
) (
  input logic                clk_i,
  input logic                rst_ni,
  sram_bank_arbiter_if.slave bus
);
  localparam int unsigned IdxW    = $clog2(NUM_PORTS);
  localparam int unsigned LcW     = $clog2(MAX_LOCK_BEATS) + 1;
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  typedef logic [IdxW-1:0] idx_t;

  idx_t           rr_ptr_q, rr_ptr_d;
  logic           own_vld_q, own_vld_d;
  idx_t           own_idx_q, own_idx_d;
  logic [LcW-1:0] lock_cnt_q, lock_cnt_d;

  logic        rr_found;
  idx_t        rr_idx;
  logic        lock_hit;
  logic        gnt_any;
  idx_t        winner;
  int unsigned rr_pos;

  logic                  cs_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BeWidth-1:0]    be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [READ_LATENCY:0]           pipe_vld_q;
  logic [READ_LATENCY:0][IdxW-1:0] pipe_idx_q;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rr_pos = (32'(rr_ptr_q) + i) % NUM_PORTS;
      if (!rr_found && bus.req_i[rr_pos]) begin
        rr_found = 1'b1;
        rr_idx   = idx_t'(rr_pos);
      end
    end
  end

  assign lock_hit = own_vld_q && bus.req_i[own_idx_q] &&
                    (lock_cnt_q < LcW'(MAX_LOCK_BEATS - 1));
  assign gnt_any  = lock_hit || rr_found;
  assign winner   = lock_hit ? own_idx_q : rr_idx;

  always_comb begin
    bus.gnt_o = '0;
    if (gnt_any) begin
      bus.gnt_o[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    own_vld_d  = 1'b0;
    own_idx_d  = own_idx_q;
    lock_cnt_d = '0;
    if (gnt_any) begin
      rr_ptr_d  = (winner == idx_t'(NUM_PORTS - 1)) ? '0 : winner + idx_t'(1);
      own_vld_d = bus.lock_i[winner];
      own_idx_d = winner;
      if (lock_hit) begin
        lock_cnt_d = lock_cnt_q + LcW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      own_vld_q  <= 1'b0;
      own_idx_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      own_vld_q  <= own_vld_d;
      own_idx_q  <= own_idx_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Bank command registers; address and data hold when idle to avoid needless toggling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      cs_q <= gnt_any;
      we_q <= gnt_any && bus.we_i[winner];
      if (gnt_any) begin
        addr_q  <= bus.addr_i[winner];
        be_q    <= bus.be_i[winner];
        wdata_q <= bus.wdata_i[winner];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_idx_q <= '0;
    end else begin
      pipe_vld_q <= {pipe_vld_q[READ_LATENCY-1:0], gnt_any && !bus.we_i[winner]};
      pipe_idx_q <= {pipe_idx_q[READ_LATENCY-1:0], winner};
    end
  end

  always_comb begin
    bus.rvalid_o = '0;
    if (pipe_vld_q[READ_LATENCY]) begin
      bus.rvalid_o[pipe_idx_q[READ_LATENCY]] = 1'b1;
    end
  end

  assign bus.rdata_o      = bus.sram_rdata_i;
  assign bus.sram_cs_o    = cs_q;
  assign bus.sram_we_o    = we_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_be_o    = be_q;
  assign bus.sram_wdata_o = wdata_q;
endmodule
